fifo_rr_arbiter: RTL and testbench

FIFO_RR_ARBITER -- requirements
Module: fifo_rr_arbiter

---
 rtl/fifo_rr_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_fifo_rr_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rr_arbiter.sv
// fifo_rr_arbiter: NUM_REQ write requesters share one FIFO through a
// round-robin arbiter. The FIFO has a single registered read port.
// Optional burst locking is compiled in when FIFO_ARB_LOCK_EN is defined.
//
// Handshake: a requester's write is accepted on the rising edge where
// req_valid[i] && req_ready[i]. req_ready is one-hot-or-zero and never
// depends on rd_en, so a full FIFO grants nobody even while being read.
// A pop is accepted on the edge where rd_en && !empty. The popped word
// appears on rd_data with rd_valid high for exactly the following cycle.
//
// arb_state is a debug view of the arbiter FSM: 0 = IDLE, 1 = LOCKED.
module fifo_rr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_lock,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  input  logic                          rd_en,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic                          rd_valid,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(DEPTH+1)-1:0]    count,
  output logic                          arb_state
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [CNT_W-1:0]      count_q;
  logic [ID_W-1:0]       last_grant_q;

  logic                  gnt_found;
  logic [ID_W-1:0]       gnt_idx;
  logic [ID_W-1:0]       cand;
  logic                  wr_en;
  logic                  rd_ok;
  logic [DATA_WIDTH-1:0] wr_data;

  arb_state_t            state_q;

  // Pointer increment with wrap, since DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

`ifdef FIFO_ARB_LOCK_EN
  arb_state_t      state_d;
  logic [ID_W-1:0] lock_id_q, lock_id_d;
  logic [3:0]      lock_cnt_q, lock_cnt_d;
`endif

  // Grant selection: round-robin search starting after last_grant,
  // overridden by the lock owner, and suppressed entirely when full.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((int'(last_grant_q) + k) % NUM_REQ);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
`ifdef FIFO_ARB_LOCK_EN
    if (state_q == LOCKED) begin
      gnt_found = req_valid[lock_id_q];
      gnt_idx   = lock_id_q;
    end
`endif
    if (full) begin
      gnt_found = 1'b0;
    end
  end

  assign req_ready = gnt_found ? (NUM_REQ'(1) << gnt_idx) : '0;
  assign grant_id  = gnt_found ? gnt_idx : '0;
  assign wr_en     = gnt_found;
  assign rd_ok     = rd_en && !empty;
  assign wr_data   = req_data[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
  assign arb_state = state_q;

`ifdef FIFO_ARB_LOCK_EN
  // Arbiter state register: lock owner and number of writes in the burst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      lock_id_q  <= '0;
      lock_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      lock_id_q  <= lock_id_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  // Arbiter next state: enter a lock on a locked write, leave it when the
  // owner drops valid, drops lock, or reaches the 8-write burst limit.
  always_comb begin
    state_d    = state_q;
    lock_id_d  = lock_id_q;
    lock_cnt_d = lock_cnt_q;
    case (state_q)
      IDLE: begin
        if (wr_en && req_lock[gnt_idx]) begin
          state_d    = LOCKED;
          lock_id_d  = gnt_idx;
          lock_cnt_d = 4'd1;
        end
      end
      LOCKED: begin
        if (!req_valid[lock_id_q]) begin
          state_d    = IDLE;
          lock_cnt_d = '0;
        end else if (wr_en) begin
          lock_cnt_d = lock_cnt_q + 4'd1;
          if (!req_lock[lock_id_q] || (lock_cnt_q == 4'd7)) begin
            state_d    = IDLE;
            lock_cnt_d = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end
`else
  logic unused_lock;
  assign unused_lock = ^req_lock;
  assign state_q     = IDLE;
`endif

  // Storage array; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  // FIFO pointers, occupancy, registered read port and round-robin history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      rd_data      <= '0;
      rd_valid     <= 1'b0;
      last_grant_q <= ID_W'(NUM_REQ-1);
    end else begin
      rd_valid <= rd_ok;
      if (wr_en) begin
        wr_ptr_q     <= ptr_inc(wr_ptr_q);
        last_grant_q <= gnt_idx;
      end
      if (rd_ok) begin
        rd_data  <= mem[rd_ptr_q];
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      case ({wr_en, rd_ok})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Directed bench for fifo_rr_arbiter (NUM_REQ=4, DEPTH=16, DATA_WIDTH=32).
// Inputs change 1 time unit after a rising edge; outputs are sampled there
// too, well away from the next active edge.
module tb_fifo_rr_arbiter;

  logic         clk;
  logic         rst;
  logic [3:0]   req_valid;
  logic [127:0] req_data;
  logic [3:0]   req_lock;
  logic [3:0]   req_ready;
  logic [1:0]   grant_id;
  logic         rd_en;
  logic [31:0]  rd_data;
  logic         rd_valid;
  logic         full;
  logic         empty;
  logic [4:0]   count;
  logic         arb_state;

  int checks;
  int errors;
  logic [31:0] exp_q[$];

  fifo_rr_arbiter #(.NUM_REQ(4), .DEPTH(16), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_lock(req_lock), .req_ready(req_ready), .grant_id(grant_id),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .full(full),
    .empty(empty), .count(count), .arb_state(arb_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    req_lock  = '0;
    req_data  = '0;
    rd_en     = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int i, input logic [31:0] d);
    req_data[i*32 +: 32] = d;
  endtask

  // Write n words from requester r with data base+k.
  task automatic fill(input int r, input int n, input logic [31:0] base);
    req_valid = 4'(1 << r);
    for (int k = 0; k < n; k++) begin
      set_data(r, base + 32'(k));
      exp_q.push_back(base + 32'(k));
      next_cycle();
    end
    req_valid = '0;
  endtask

  // Pop n words and compare against the expected queue.
  task automatic drain(input int n, input string name);
    logic [31:0] e;
    rd_en = 1'b1;
    for (int k = 0; k < n; k++) begin
      next_cycle();
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== e) begin
        $display("FAIL %s[%0d]: rd_valid=%b rd_data=%h, required 1 / %h", name, k, rd_valid, rd_data, e);
        errors++;
      end
    end
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0 || rd_valid !== 1'b0 ||
        rd_data !== 32'h0 || req_ready !== 4'h0 || grant_id !== 2'd0 || arb_state !== 1'b0) begin
      $display("FAIL reset: count=%0d empty=%b full=%b rd_valid=%b rd_data=%h ready=%b gid=%0d st=%b",
               count, empty, full, rd_valid, rd_data, req_ready, grant_id, arb_state);
      errors++;
    end
  endtask

  task automatic test_round_robin();
    logic [31:0] e;
    do_reset();
    exp_q.delete();
    for (int i = 0; i < 4; i++) set_data(i, 32'hA0 + 32'(i));
    req_valid = 4'hF;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (grant_id !== 2'(i % 4) || req_ready !== 4'(1 << (i % 4))) begin
        $display("FAIL rr_grant[%0d]: gid=%0d ready=%b, required %0d / %b",
                 i, grant_id, req_ready, i % 4, 4'(1 << (i % 4)));
        errors++;
      end
      next_cycle();
    end
    req_valid = '0;
    checks++;
    if (count !== 5'd5) begin
      $display("FAIL rr_count: count=%0d, required 5", count);
      errors++;
    end
    rd_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      e = 32'hA0 + 32'(i % 4);
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== e) begin
        $display("FAIL rr_read[%0d]: rd_valid=%b rd_data=%h, required 1 / %h", i, rd_valid, rd_data, e);
        errors++;
      end
    end
    rd_en = 1'b0;
    next_cycle();
    checks++;
    if (rd_valid !== 1'b0 || empty !== 1'b1) begin
      $display("FAIL rr_after: rd_valid=%b empty=%b, required 0 / 1", rd_valid, empty);
      errors++;
    end
  endtask

  task automatic test_full();
    do_reset();
    exp_q.delete();
    req_valid = 4'b0010;
    for (int k = 0; k < 16; k++) begin
      set_data(1, 32'h100 + 32'(k));
      exp_q.push_back(32'h100 + 32'(k));
      #1;
      checks++;
      if (req_ready !== 4'b0010) begin
        $display("FAIL full_fill_ready[%0d]: ready=%b, required 0010", k, req_ready);
        errors++;
      end
      next_cycle();
    end
    set_data(1, 32'h1FF);
    #1;
    checks++;
    if (full !== 1'b1 || count !== 5'd16 || req_ready !== 4'b0000) begin
      $display("FAIL full_state: full=%b count=%0d ready=%b, required 1 / 16 / 0000", full, count, req_ready);
      errors++;
    end
    rd_en = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0000) begin
      $display("FAIL full_ready_with_rd: ready=%b, required 0000", req_ready);
      errors++;
    end
    next_cycle();
    rd_en = 1'b0;
    req_valid = '0;
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== exp_q[0] || full !== 1'b0 || count !== 5'd15) begin
      $display("FAIL full_pop: rd_valid=%b rd_data=%h full=%b count=%0d, required 1 / 00000100 / 0 / 15",
               rd_valid, rd_data, full, count);
      errors++;
    end
    void'(exp_q.pop_front());
    req_valid = 4'b0010;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      $display("FAIL full_regrant: ready=%b, required 0010", req_ready);
      errors++;
    end
    req_valid = '0;
    drain(15, "full_drain");
  endtask

  task automatic test_empty_read();
    rd_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      checks++;
      if (rd_valid !== 1'b0 || count !== 5'd0 || empty !== 1'b1 || rd_data !== 32'h10F) begin
        $display("FAIL empty_read[%0d]: rd_valid=%b count=%0d empty=%b rd_data=%h, required 0 / 0 / 1 / 0000010f",
                 k, rd_valid, count, empty, rd_data);
        errors++;
      end
    end
    rd_en = 1'b0;
  endtask

  task automatic test_simultaneous();
    do_reset();
    exp_q.delete();
    fill(0, 5, 32'h10);
    req_valid = 4'b0001;
    set_data(0, 32'h55);
    exp_q.push_back(32'h55);
    rd_en = 1'b1;
    next_cycle();
    req_valid = '0;
    rd_en = 1'b0;
    checks++;
    if (count !== 5'd5 || rd_valid !== 1'b1 || rd_data !== 32'h10) begin
      $display("FAIL simul: count=%0d rd_valid=%b rd_data=%h, required 5 / 1 / 00000010", count, rd_valid, rd_data);
      errors++;
    end
    void'(exp_q.pop_front());
    drain(5, "simul_drain");
  endtask

  task automatic test_empty_write_read();
    do_reset();
    exp_q.delete();
    req_valid = 4'b0001;
    set_data(0, 32'h77);
    rd_en = 1'b1;
    next_cycle();
    req_valid = '0;
    checks++;
    if (rd_valid !== 1'b0 || count !== 5'd1) begin
      $display("FAIL empty_wr_rd: rd_valid=%b count=%0d, required 0 / 1", rd_valid, count);
      errors++;
    end
    next_cycle();
    rd_en = 1'b0;
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 32'h77 || count !== 5'd0) begin
      $display("FAIL empty_wr_rd_pop: rd_valid=%b rd_data=%h count=%0d, required 1 / 00000077 / 0",
               rd_valid, rd_data, count);
      errors++;
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    exp_q.delete();
    fill(2, 8, 32'h200);
    rd_en = 1'b1;
    next_cycle();
    rd_en = 1'b0;
    checks++;
    if (count !== 5'd7 || rd_valid !== 1'b1) begin
      $display("FAIL mid_reset_pre: count=%0d rd_valid=%b, required 7 / 1", count, rd_valid);
      errors++;
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (count !== 5'd0 || empty !== 1'b1 || rd_valid !== 1'b0) begin
      $display("FAIL mid_reset_async: count=%0d empty=%b rd_valid=%b, required 0 / 1 / 0", count, empty, rd_valid);
      errors++;
    end
    #1;
    rst = 1'b0;
    req_valid = 4'hF;
    #1;
    checks++;
    if (grant_id !== 2'd0 || req_ready !== 4'b0001) begin
      $display("FAIL mid_reset_grant: gid=%0d ready=%b, required 0 / 0001", grant_id, req_ready);
      errors++;
    end
    req_valid = '0;
    exp_q.delete();
  endtask

  task automatic test_lock();
    logic [1:0] exp_g [10];
`ifdef FIFO_ARB_LOCK_EN
    exp_g = '{2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd3};
`else
    exp_g = '{2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd3, 2'd1};
`endif
    do_reset();
    for (int i = 0; i < 4; i++) set_data(i, 32'hC0 + 32'(i));
    req_valid = 4'b1110;
    req_lock  = 4'b0100;
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++;
      if (grant_id !== exp_g[i] || req_ready !== 4'(1 << exp_g[i])) begin
        $display("FAIL lock_grant[%0d]: gid=%0d ready=%b, required %0d", i, grant_id, req_ready, exp_g[i]);
        errors++;
      end
      next_cycle();
    end
    req_valid = '0;
    req_lock  = '0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_round_robin();
    test_full();
    test_empty_read();
    test_simultaneous();
    test_empty_write_read();
    test_mid_reset();
    test_lock();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
